// File: rtl/vram_fetch_arbiter.sv
// vram_fetch_arbiter: shares one VRAM port between display prefetch/pixel shift and CPU accesses
module vram_fetch_arbiter #(
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 8,
  parameter int WORDS_PER_LINE = 100
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              frame_start,
  input  logic              line_start,
  input  logic              de,
  output logic              pix_o,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam int PH_W = $clog2(DATA_W);
  localparam int IDX_W = $clog2(WORDS_PER_LINE + 1);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(DATA_W - 1);
  localparam logic [IDX_W-1:0] IDX_END = IDX_W'(WORDS_PER_LINE);
  localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(WORDS_PER_LINE);
  typedef enum logic [1:0] {IDLE, DISP, CPU} state_t;
  state_t state, state_nxt;
  logic live, skip, disp_pend, rd_first, cpu_rd, disp_req, cpu_go;
  logic [ADDR_W-1:0] line_base;
  logic [IDX_W-1:0] idx;
  logic [PH_W-1:0] phase;
  logic [DATA_W-1:0] cur_word, next_word;
  assign disp_req = live && (disp_pend || (de && phase == '0 && idx < IDX_END));
  assign cpu_go = live && cpu_req && !disp_req && state != CPU;
  assign cpu_ack = state == CPU;
  assign cpu_rdata = (cpu_ack && cpu_rd) ? mem_rdata : '0;
  // state holds the access issued last cycle; live keeps the port quiet until the cycle after clear
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state <= IDLE;
      live <= 1'b0;
      cpu_rd <= 1'b0;
    end else begin
      state <= state_nxt;
      live <= 1'b1;
      cpu_rd <= cpu_go && !cpu_we;
    end
  end
  // display fetches win; the CPU gets the next slot that is neither a fetch nor its own ack cycle
  always_comb begin
    state_nxt = disp_req ? DISP : (cpu_go ? CPU : IDLE);
    mem_en = state_nxt != IDLE;
    mem_we = state_nxt == CPU && cpu_we;
    mem_addr = state_nxt == CPU ? cpu_addr : (state_nxt == DISP ? line_base + ADDR_W'(idx) : '0);
    mem_wdata = (state_nxt == CPU && cpu_we) ? cpu_wdata : '0;
  end
  // line base and word index; the first line after frame_start stays at base 0
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      line_base <= '0;
      skip <= 1'b0;
      disp_pend <= 1'b0;
      idx <= '0;
      rd_first <= 1'b0;
    end else begin
      disp_pend <= line_start;
      rd_first <= disp_req && idx == '0;
      idx <= line_start ? '0 : (disp_req ? idx + 1'b1 : idx);
      skip <= frame_start ? 1'b1 : (line_start ? 1'b0 : skip);
      line_base <= frame_start ? '0 : ((line_start && !skip) ? line_base + LINE_STEP : line_base);
    end
  end
  // pixel shifter: word 0 lands in cur_word, later words wait in next_word until the last phase
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      phase <= '0;
      cur_word <= '0;
      next_word <= '0;
      pix_o <= 1'b0;
    end else begin
      phase <= line_start ? '0 : (de ? phase + 1'b1 : phase);
      pix_o <= de && cur_word[PH_LAST - phase];
      next_word <= (state == DISP && !rd_first) ? mem_rdata : next_word;
      cur_word <= (state == DISP && rd_first) ? mem_rdata : ((de && phase == PH_LAST) ? next_word : cur_word);
    end
  end
endmodule

// File: tb/tb_vram_fetch_arbiter.sv
// tb_vram_fetch_arbiter: scoreboard bench for the VRAM fetch arbiter
module tb_vram_fetch_arbiter;
  logic clk = 1'b0, clr_n = 1'b0, frame_start = 1'b0, line_start = 1'b0, de = 1'b0;
  logic pix_o, cpu_req = 1'b0, cpu_we = 1'b0, cpu_ack;
  logic [15:0] cpu_addr = '0, mem_addr;
  logic [7:0] cpu_wdata = '0, cpu_rdata, mem_wdata, mem_rdata = '0;
  logic mem_en, mem_we;
  logic [7:0] ram [0:65535];
  int cyc = 0, n_chk = 0, n_fail = 0, rd_cnt = 0;
  typedef struct {int cyc; logic we; logic [15:0] addr; logic [7:0] wdata;} mem_t;
  typedef struct {int cyc; logic rd; logic [7:0] data;} ack_t;
  typedef struct {int cyc; logic v;} pix_t;
  mem_t mem_q[$];
  ack_t ack_q[$];
  pix_t pix_q[$];
  mem_t me;
  ack_t ae;
  pix_t pe;

  vram_fetch_arbiter dut (
    .clk(clk), .clr_n(clr_n), .frame_start(frame_start), .line_start(line_start), .de(de),
    .pix_o(pix_o), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] pat(input int a);
    return a == 0 ? 8'hA5 : (a == 1 ? 8'h3C : 8'(a * 7 + 3));
  endfunction

  initial for (int i = 0; i < 65536; i++) ram[i] = pat(i);

  always @(posedge clk)
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else mem_rdata <= ram[mem_addr];
    end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push_mem(input int c, input logic we, input int a, input logic [7:0] wd);
    mem_t m;
    m.cyc = c; m.we = we; m.addr = 16'(a); m.wdata = wd;
    mem_q.push_back(m);
  endtask

  task automatic push_ack(input int c, input logic rd, input logic [7:0] d);
    ack_t x;
    x.cyc = c; x.rd = rd; x.data = d;
    ack_q.push_back(x);
  endtask

  task automatic push_pix(input int c, input logic v);
    pix_t x;
    x.cyc = c; x.v = v;
    pix_q.push_back(x);
  endtask

  always @(negedge clk) begin
    if (mem_en) begin
      if (!mem_we) rd_cnt++;
      if (mem_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_mem: got we=%0b addr=%0h expected no access (cycle %0d)", mem_we, mem_addr, cyc);
      end else begin
        me = mem_q.pop_front();
        chk("mem_cycle", cyc, me.cyc);
        chk("mem_we", {31'd0, mem_we}, {31'd0, me.we});
        chk("mem_addr", {16'd0, mem_addr}, {16'd0, me.addr});
        if (me.we) chk("mem_wdata", {24'd0, mem_wdata}, {24'd0, me.wdata});
      end
    end
    if (cpu_ack) begin
      if (ack_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_ack: got ack expected none (cycle %0d)", cyc);
      end else begin
        ae = ack_q.pop_front();
        chk("ack_cycle", cyc, ae.cyc);
        if (ae.rd) chk("cpu_rdata", {24'd0, cpu_rdata}, {24'd0, ae.data});
      end
    end
    if (pix_q.size() > 0 && pix_q[0].cyc == cyc) begin
      pe = pix_q.pop_front();
      chk("pix_o", {31'd0, pix_o}, {31'd0, pe.v});
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string nm);
    chk({nm, "_mem_en"}, {31'd0, mem_en}, 0);
    chk({nm, "_mem_we"}, {31'd0, mem_we}, 0);
    chk({nm, "_mem_addr"}, {16'd0, mem_addr}, 0);
    chk({nm, "_mem_wdata"}, {24'd0, mem_wdata}, 0);
    chk({nm, "_cpu_ack"}, {31'd0, cpu_ack}, 0);
    chk({nm, "_cpu_rdata"}, {24'd0, cpu_rdata}, 0);
    chk({nm, "_pix_o"}, {31'd0, pix_o}, 0);
  endtask

  task automatic line(input int base, input int nde, input bit contend);
    int d;
    logic [7:0] wd;
    tick;
    line_start = 1'b1;
    push_mem(cyc + 1, 1'b0, base, 8'h00);
    tick;
    line_start = 1'b0;
    tick;
    tick;
    de = 1'b1;
    d = cyc;
    push_mem(d, 1'b0, base + 1, 8'h00);
    if (contend) begin
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0200; cpu_wdata = 8'h99;
      push_mem(d + 1, 1'b1, 16'h0200, 8'h99);
      push_ack(d + 2, 1'b0, 8'h00);
    end
    for (int w = 2; w < 100 && (w - 1) * 8 < nde; w++) push_mem(d + 8 * (w - 1), 1'b0, base + w, 8'h00);
    for (int k = 0; k < nde; k++) begin
      wd = pat(base + k / 8);
      push_pix(d + 1 + k, wd[7 - k % 8]);
    end
    for (int k = 0; k < nde; k++) begin
      tick;
      if (cpu_ack) cpu_req = 1'b0;
    end
    de = 1'b0;
    cpu_req = 1'b0;
  endtask

  task automatic cpu_op(input logic we, input logic [15:0] a, input logic [7:0] wd, input logic [7:0] rd_exp);
    tick;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
    push_mem(cyc, we, a, we ? wd : 8'h00);
    push_ack(cyc + 1, !we, rd_exp);
    for (int i = 0; i < 8; i++) begin
      tick;
      if (cpu_ack) break;
    end
    cpu_req = 1'b0;
  endtask

  initial begin
    int n0;
    tick;
    tick;
    check_zero("reset");
    clr_n = 1'b1;
    repeat (3) tick;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0042; cpu_wdata = 8'h77;
    #1;
    chk("grant_en", {31'd0, mem_en}, 1);
    chk("grant_we", {31'd0, mem_we}, 1);
    chk("grant_addr", {16'd0, mem_addr}, 32'h42);
    clr_n = 1'b0;
    #1;
    check_zero("midreset");
    cpu_req = 1'b0;
    tick;
    tick;
    clr_n = 1'b1;
    repeat (4) begin
      tick;
      chk("no_ack_after_reset", {31'd0, cpu_ack}, 0);
    end
    tick;
    frame_start = 1'b1;
    tick;
    frame_start = 1'b0;
    line(0, 16, 1'b0);
    repeat (4) tick;
    line(100, 16, 1'b1);
    repeat (4) tick;
    cpu_op(1'b1, 16'h1234, 8'h5A, 8'h00);
    cpu_op(1'b0, 16'h1234, 8'h00, 8'h5A);
    repeat (4) tick;
    n0 = rd_cnt;
    line(200, 800, 1'b0);
    repeat (20) tick;
    chk("line_reads", rd_cnt - n0, 100);
    chk("mem_left", mem_q.size(), 0);
    chk("ack_left", ack_q.size(), 0);
    chk("pix_left", pix_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end
endmodule
